// File: rtl/bram_bitmap_reader.sv
// Reads a run of consecutive bitmap RAM words and serialises them as a valid/ready bit stream.
// Optional build macro BITMAP_READER_LSB_FIRST_EN: emit each word bit 0 first instead of MSB first.
module bram_bitmap_reader #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_cnt,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          bit_valid,
    output logic          bit_data,
    output logic          bit_last,
    input  logic          bit_ready
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, SHIFT, FIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] ram_addr_reg, ram_addr_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          bit_valid_reg, bit_valid_next;
    logic [DW-1:0] shift_reg, shift_next;
    logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [AW:0]   words_left_reg, words_left_next;
    logic [DW-1:0] load_word;
    logic          handshake;

    // The shifter always emits from the top bit; bit order is chosen when the word is loaded.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_load
`ifdef BITMAP_READER_LSB_FIRST_EN
            assign load_word[gi] = ram_dout[DW-1-gi];
`else
            assign load_word[gi] = ram_dout[gi];
`endif
        end
    endgenerate

    assign handshake = bit_valid_reg && bit_ready;

    always_comb begin
        state_next      = state_reg;
        ram_addr_next   = ram_addr_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        bit_valid_next  = bit_valid_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        words_left_next = words_left_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        words_left_next = word_cnt;
                        ram_addr_next   = base_addr;
                        busy_next       = 1'b1;
                        state_next      = ADDR;
                    end else begin
                        done_next  = 1'b1;
                        state_next = FIN;
                    end
                end
            end
            ADDR: state_next = LOAD;
            LOAD: begin
                shift_next     = load_word;
                bit_cnt_next   = CW'(DW - 1);
                bit_valid_next = 1'b1;
                state_next     = SHIFT;
            end
            SHIFT: begin
                if (handshake) begin
                    shift_next = shift_reg << 1;
                    if (bit_cnt_reg != '0) begin
                        bit_cnt_next = bit_cnt_reg - CW'(1);
                    end else begin
                        bit_valid_next = 1'b0;
                        if (words_left_reg > (AW+1)'(1)) begin
                            words_left_next = words_left_reg - (AW+1)'(1);
                            ram_addr_next   = ram_addr_reg + AW'(1);
                            state_next      = ADDR;
                        end else begin
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = FIN;
                        end
                    end
                end
            end
            FIN: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ram_addr_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            bit_valid_reg  <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            words_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ram_addr_reg   <= ram_addr_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            bit_valid_reg  <= bit_valid_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            words_left_reg <= words_left_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_we    = 1'b0;
    assign bit_valid = bit_valid_reg;
    assign bit_data  = shift_reg[DW-1];
    assign bit_last  = bit_valid_reg && (bit_cnt_reg == '0) && (words_left_reg == (AW+1)'(1));

endmodule

// File: tb/tb_bram_bitmap_reader.sv
// Directed bench for bram_bitmap_reader with a registered-address RAM model and immediate assertions.
module tb_bram_bitmap_reader;
    localparam int DW = 8;
    localparam int AW = 10;

`ifdef BITMAP_READER_LSB_FIRST_EN
    localparam logic [31:0] EXP_01 = 32'h80;
    localparam logic [31:0] EXP_SCAN3 = 32'hFF0081;
`else
    localparam logic [31:0] EXP_01 = 32'h01;
    localparam logic [31:0] EXP_SCAN3 = 32'hFF0081;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_cnt;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          bit_valid;
    logic          bit_data;
    logic          bit_last;
    logic          bit_ready;

    always #5 clk = ~clk;

    bram_bitmap_reader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last), .bit_ready(bit_ready)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) ram_addr_q <= ram_addr;
    assign ram_dout = mem[ram_addr_q];

    int n_assert = 0;
    int n_fail = 0;

    int          first_valid_k, done_k, last_cnt, last_pos, nbits;
    int          low_cycles, stall_err, busy_seen, final_hs_k;
    logic [31:0] bits_val;
    int          addr_seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
        base_addr = b;
        word_cnt  = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Call right after do_start; k counts edges with the start edge as 1.
    task automatic run_scan(input string name, input bit rnd_ready, input int budget);
        int   k;
        logic prev_stall, prev_data, prev_last;
        first_valid_k = -1; done_k = -1; last_cnt = 0; last_pos = -1; nbits = 0;
        low_cycles = 0; stall_err = 0; busy_seen = 0; final_hs_k = -1; bits_val = '0;
        addr_seq.delete();
        prev_stall = 1'b0; prev_data = 1'b0; prev_last = 1'b0;
        k = 1;
        while (1) begin
            if (busy) begin
                busy_seen = 1;
                if (addr_seq.size() == 0 || addr_seq[$] != int'(ram_addr)) addr_seq.push_back(int'(ram_addr));
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (k > budget) begin
                check({name, "_timeout"}, k, budget);
                break;
            end
            if (bit_valid) begin
                if (first_valid_k < 0) first_valid_k = k;
            end else if (first_valid_k >= 0) begin
                low_cycles++;
            end
            if (prev_stall && (!bit_valid || bit_data !== prev_data || bit_last !== prev_last)) stall_err++;
            bit_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bit_valid && bit_ready) begin
                bits_val = {bits_val[30:0], bit_data};
                nbits++;
                if (bit_last) begin
                    last_cnt++;
                    last_pos = nbits - 1;
                end
                final_hs_k = k + 1;
            end
            prev_stall = bit_valid && !bit_ready;
            prev_data  = bit_data;
            prev_last  = bit_last;
            tick();
            k++;
        end
        bit_ready = 1'b1;
        $display("scan %s: bits=%0d value=%h first_valid=%0d done_edge=%0d last_cnt=%0d",
                 name, nbits, bits_val, first_valid_k, done_k, last_cnt);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; bit_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_data", bit_data, 0);
        check("rst_bit_last", bit_last, 0);

        // Single word A5
        mem[5] = 8'hA5;
        do_start(10'd5, 11'd1);
        run_scan("a5", 1'b0, 100);
        check("a5_first_valid_edge", first_valid_k, 3);
        check("a5_bits", bits_val, 32'hA5);
        check("a5_nbits", nbits, 8);
        check("a5_last_cnt", last_cnt, 1);
        check("a5_last_pos", last_pos, 7);
        check("a5_edges_to_done", done_k - 1, 10);
        check("a5_addr", addr_seq[0], 5);
        tick();
        check("a5_done_one_cycle", done, 0);

        // Single word 01 distinguishes bit order
        mem[5] = 8'h01;
        do_start(10'd5, 11'd1);
        run_scan("w01", 1'b0, 100);
        check("w01_bits", bits_val, EXP_01);
        check("w01_last_pos", last_pos, 7);
        tick();

        // Three words across the address wrap
        mem[1022] = 8'hFF; mem[1023] = 8'h00; mem[0] = 8'h81;
        do_start(10'd1022, 11'd3);
        run_scan("wrap", 1'b0, 200);
        check("wrap_bits", bits_val, EXP_SCAN3);
        check("wrap_nbits", nbits, 24);
        check("wrap_addr_cnt", addr_seq.size(), 3);
        if (addr_seq.size() == 3) begin
            check("wrap_addr0", addr_seq[0], 1022);
            check("wrap_addr1", addr_seq[1], 1023);
            check("wrap_addr2", addr_seq[2], 0);
        end
        check("wrap_bubble_cycles", low_cycles, 4);
        check("wrap_last_cnt", last_cnt, 1);
        check("wrap_last_pos", last_pos, 23);
        check("wrap_edges_to_done", done_k - 1, 30);
        tick();

        // Same run under random backpressure
        do_start(10'd1022, 11'd3);
        run_scan("stall", 1'b1, 2000);
        check("stall_bits", bits_val, EXP_SCAN3);
        check("stall_nbits", nbits, 24);
        check("stall_stability", stall_err, 0);
        check("stall_bubble_cycles", low_cycles, 4);
        check("stall_last_cnt", last_cnt, 1);
        check("stall_done_after_final_hs", done_k, final_hs_k);
        tick();

        // Zero-word scan
        do_start(10'd77, 11'd0);
        run_scan("zero", 1'b0, 20);
        check("zero_done_edge", done_k, 1);
        check("zero_nbits", nbits, 0);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_first_valid", first_valid_k, -1);
        check("zero_ram_addr", ram_addr, 0);
        tick();

        // Restart ignored mid-scan, then reset during SHIFT
        mem[5] = 8'hA5;
        do_start(10'd5, 11'd1);
        tick(); tick();
        check("abort_valid", bit_valid, 1);
        bit_ready = 1'b0;
        do_start(10'd1022, 11'd3);
        check("abort_hold_valid", bit_valid, 1);
        check("abort_hold_data", bit_data, 1);
        check("abort_addr_kept", ram_addr, 5);
        check("abort_busy", busy, 1);
        bit_ready = 1'b1;
        tick();
        check("abort_second_bit", bit_data, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_rst_outputs", {busy, done, bit_valid, bit_data, bit_last, ram_we}, 0);
        check("abort_rst_addr", ram_addr, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_quiet", {done, busy, bit_valid}, 0);
        end
        do_start(10'd5, 11'd1);
        run_scan("after_rst", 1'b0, 100);
        check("after_rst_bits", bits_val, 32'hA5);
        check("after_rst_edges_to_done", done_k - 1, 10);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
